sum_uart_tx: RTL and testbench
==============================

# sum_uart_tx

Serial transmitter that sits directly downstream of the top-level sum/counter stage. It accepts one 8-bit result per valid/ready handshake and shifts it out as an asynchronous 8N1 frame, LSB first, on a single output pin, so the registered `uo_out` value can be read with a plain UART receiver. It occupies one bit of the dedicated output bus, and the top level drives `busy` onto a second bit.

## Interface
- `CLK_DIV`, default 16: clock cycles per serial bit; legal range 2..65535.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_data`  input  8  byte to transmit; sampled only on the accept cycle.
- `in_valid`  input  1  producer has a byte.
- `in_ready`  output  1  block can accept; high only in IDLE.
- `tx`  output  1  serial line; idle high; registered.
- `busy`  output  1  frame in progress (any state other than IDLE); registered.

## Operation
- Accept: `in_valid & in_ready` at a rising edge captures `in_data` into the shift register and moves to START. This edge is the only accept point.
- After accept, `in_data` and `in_valid` are don't-care until `in_ready` returns high.
- States:
  - IDLE: `tx`=1, `busy`=0, `in_ready`=1.
  - START: `tx`=0 for CLK_DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLK_DIV cycles. The bit index runs 0..7; after bit 7 the next state is PARITY if enabled, else STOP.
  - PARITY (optional): one bit period.
  - STOP: `tx`=1 for CLK_DIV cycles, then IDLE.
- Bit timer: counts 0..CLK_DIV-1. It reloads to 0 on every state or bit change. Its width is $clog2(CLK_DIV).
- `in_ready` is combinational from state (state==IDLE). `in_valid` is not in its path.
- `in_valid` held high continuously gives back-to-back frames separated by exactly one IDLE cycle.
- There is no abort input. The only way to abort a frame is reset.

## Timing
- Reset values: `tx`=1, `busy`=0, `in_ready`=1, state IDLE, bit timer 0, bit index 0, shift register 0x00.
- Latency: accept at edge N gives `tx`=0 and `busy`=1 from edge N until the start bit is complete. `tx` and `busy` change on the same edge as the state change. They are driven from next-state logic into flops, so there is no extra pipeline cycle.
- Frame length: 10·CLK_DIV cycles (11·CLK_DIV with parity).
- Frame period under continuous valid: 10·CLK_DIV+1 cycles (11·CLK_DIV+1 with parity).
- Reset mid-frame: `tx` goes to 1 and `busy` to 0 immediately (asynchronous). The partial frame is lost; the receiver sees a framing error, which is acceptable.
- Reset deassertion: the first accept can occur on the first rising edge after deassertion.

## Configuration
- `SUM_UART_TX_PARITY_EN` defined: the PARITY state is compiled in.
  - The parity bit is even parity: XOR of the 8 data bits, sent after bit 7.
- Macro undefined: no PARITY state, no parity logic; STOP follows bit 7 directly.

## Structure
- Package `sum_uart_pkg` holds:
  - enum `tx_state_e` {IDLE, START, DATA, PARITY, STOP}, 3 bits wide.
  - `DATA_W` = 8.
  - `IDLE_LEVEL` = 1'b1.
- Sub-module `baud_tick`, parameterised by CLK_DIV:
  - inputs: `clk`, `rst_n`, `clear`.
  - output: `tick`, high in the last cycle of each bit period.
  - The FSM asserts `clear` on every state or bit change.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release → `tx`=1, `busy`=0, `in_ready`=1; no `tx` activity for 50 cycles with `in_valid`=0.
- Single byte, CLK_DIV=4, `in_data`=0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 cycles. `busy` is high for 40 cycles, then `in_ready`=1.
- Back-to-back, CLK_DIV=4, `in_valid` held high, bytes 0x00 then 0xFF → two frames 41 cycles apart start-to-start, with exactly one idle-high cycle between them; the second byte is accepted only when `in_ready`=1.
- Data stability: change `in_data` every cycle during a frame of 0x3C → transmitted bits still decode to 0x3C.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 3 → `tx`=1 and `busy`=0 within the same cycle. After release, a new 0x55 frame is transmitted correctly.
- Parity build, CLK_DIV=4, 0x07 → parity bit 1; 0x03 → parity bit 0. Frame is 44 cycles.

Source files
------------

// File: rtl/sum_uart_pkg.sv
// sum_uart_pkg: shared types and constants for the sum/counter UART transmitter
package sum_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  localparam int DATA_W = 8;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/sum_uart_tx_baud_tick.sv
// baud_tick: bit-period timer, tick high in the last cycle of each CLK_DIV-cycle bit
module baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sum_uart_tx.sv
// sum_uart_tx: 8N1 serial transmitter with valid/ready input, LSB first.
// Define SUM_UART_TX_PARITY_EN to insert an even parity bit after bit 7.
module sum_uart_tx
  import sum_uart_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);
  tx_state_e                 state;
  logic [DATA_W-1:0]         sh;
  logic [$clog2(DATA_W)-1:0] idx;
  logic                      tick;
`ifdef SUM_UART_TX_PARITY_EN
  logic                      par;
`endif
  assign in_ready = state == IDLE;
  // every tick ends a bit or a state, and IDLE holds the timer at zero
  baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(in_ready | tick),
    .tick (tick)
  );
  // tx/busy are loaded alongside the state so they change on the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      idx   <= '0;
      tx    <= IDLE_LEVEL;
      busy  <= 1'b0;
`ifdef SUM_UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= START;
          sh    <= in_data;
          idx   <= '0;
          tx    <= 1'b0;
          busy  <= 1'b1;
`ifdef SUM_UART_TX_PARITY_EN
          par   <= ^in_data;
`endif
        end
        START: if (tick) begin
          state <= DATA;
          tx    <= sh[0];
        end
        DATA: if (tick) begin
          idx <= idx + 1'b1;
          sh  <= sh >> 1;
          if (idx == '1) begin
`ifdef SUM_UART_TX_PARITY_EN
            state <= PARITY;
            tx    <= par;
`else
            state <= STOP;
            tx    <= IDLE_LEVEL;
`endif
          end else tx <= sh[1];
        end
`ifdef SUM_UART_TX_PARITY_EN
        PARITY: if (tick) begin
          state <= STOP;
          tx    <= IDLE_LEVEL;
        end
`endif
        STOP: if (tick) begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_sum_uart_tx.sv
// tb_sum_uart_tx: directed checks of sum_uart_tx at CLK_DIV=4, sampled on the falling edge.
module tb_sum_uart_tx;
  localparam int DIV = 4;
`ifdef SUM_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic in_ready, tx, busy;

  int vectors = 0;
  int miscompares = 0;
  logic txs [0:199];
  logic bsy [0:199];
  logic rdy [0:199];

  sum_uart_tx #(.CLK_DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef SUM_UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // called at a falling edge; the next rising edge is the accept point
  task automatic capture(input int n, input logic keep_valid, input logic scramble, input logic [7:0] next_data);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      txs[i] = tx;
      bsy[i] = busy;
      rdy[i] = in_ready;
      in_data = scramble ? 8'($urandom) : next_data;
      in_valid = keep_valid;
    end
  endtask

  task automatic check_frame(input string tag, input int base, input logic [10:0] exp);
    logic [10:0] bits;
    logic held;
    int nb;
    bits = '0;
    held = 1'b1;
    nb = 0;
    for (int j = 0; j < NB; j++) begin
      bits[j] = txs[base + DIV * j];
      for (int k = 0; k < DIV; k++)
        if (txs[base + DIV * j + k] !== bits[j]) held = 1'b0;
    end
    for (int i = 0; i < FL; i++) if (bsy[base + i] === 1'b1) nb++;
    chk({tag, "_bits"}, 32'(bits), 32'(exp));
    chk({tag, "_held"}, 32'(held), 32'd1);
    chk({tag, "_busy_len"}, nb, FL);
    chk({tag, "_end_tx"}, 32'(txs[base + FL]), 32'd1);
    chk({tag, "_end_busy"}, 32'(bsy[base + FL]), 32'd0);
    chk({tag, "_end_ready"}, 32'(rdy[base + FL]), 32'd1);
  endtask

  initial begin
    int bad;
    int gap;
    int rdy_hi;
    // reset held for three cycles
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    chk("idle_quiet", bad, 0);

    // single 0xA5 frame
    in_data = 8'hA5;
    in_valid = 1'b1;
    capture(FL + 1, 1'b0, 1'b0, 8'h00);
`ifdef SUM_UART_TX_PARITY_EN
    check_frame("a5", 0, 11'b10101001010);
`else
    check_frame("a5", 0, 11'b01101001010);
`endif

    // back-to-back 0x00 then 0xFF with valid held high
    @(negedge clk);
    in_data = 8'h00;
    in_valid = 1'b1;
    capture(2 * (FL + 1), 1'b1, 1'b0, 8'hFF);
    in_valid = 1'b0;
    check_frame("b2b0", 0, frame_of(8'h00));
    check_frame("b2b1", FL + 1, frame_of(8'hFF));
    gap = -1;
    for (int i = FL; i < 2 * FL; i++) if (gap < 0 && txs[i] === 1'b0) gap = i;
    chk("b2b_start_gap", gap, FL + 1);
    rdy_hi = 0;
    for (int i = 0; i < FL; i++) if (rdy[i] !== 1'b0) rdy_hi++;
    chk("b2b_ready_low", rdy_hi, 0);
    @(negedge clk);

    // data stability: in_data scrambled every cycle during the frame
    in_data = 8'h3C;
    in_valid = 1'b1;
    capture(FL + 1, 1'b0, 1'b1, 8'h00);
    check_frame("stable", 0, frame_of(8'h3C));

    // reset asserted during data bit 3 of 0x55
    @(negedge clk);
    in_data = 8'h55;
    in_valid = 1'b1;
    capture(DIV * 4 + 1, 1'b0, 1'b0, 8'h00);
    chk("mid_bit3_tx", 32'(tx), 32'd0);
    chk("mid_bit3_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    in_data = 8'h55;
    in_valid = 1'b1;
    capture(FL + 1, 1'b0, 1'b0, 8'h00);
    check_frame("after_rst", 0, frame_of(8'h55));

`ifdef SUM_UART_TX_PARITY_EN
    @(negedge clk);
    in_data = 8'h07;
    in_valid = 1'b1;
    capture(FL + 1, 1'b0, 1'b0, 8'h00);
    check_frame("par07", 0, 11'b11000001110);
    chk("par07_bit", 32'(txs[9 * DIV]), 32'd1);
    @(negedge clk);
    in_data = 8'h03;
    in_valid = 1'b1;
    capture(FL + 1, 1'b0, 1'b0, 8'h00);
    check_frame("par03", 0, 11'b10000000110);
    chk("par03_bit", 32'(txs[9 * DIV]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
